// File: rtl/count_uart_reporter.sv
// -----------------------------------------------------------------------------
// count_uart_reporter
//
// Watches a small count value (e.g. a rotary encoder position). Whenever it
// changes, the new value goes out on a UART TX line as one ASCII hex digit
// followed by CR and LF. Changes that arrive while a message is in flight
// are not queued. When the line goes idle again, the current count is
// compared with the last value reported, so a burst of changes is merged
// into at most one follow-up message.
//
// Optional feature (compile-time macro REPORT_DIR_EN):
//   When defined, each message starts with a direction byte before the
//   digit: '+' or '-'. The byte is taken from the MSB of
//   (new - previous) mod 2^COUNT_W. Messages are then 4 bytes long.
//
// Parameters:
//   CLK_HZ   system clock frequency in Hz
//   BAUD     UART bit rate; bit period DIV = CLK_HZ / BAUD clock cycles
//   COUNT_W  width of count_in (1..4), zero-extended to one hex digit
//
// Ports:
//   clk       in   system clock, rising edge
//   rstn      in   synchronous active-low reset
//   count_in  in   count value, already in the clk domain
//   uart_tx   out  serial data, 8N1, LSB first, idle high (registered)
//   busy      out  high from the first start bit to the end of the last
//                  stop bit of a message (registered)
// -----------------------------------------------------------------------------
module count_uart_reporter #(
    parameter int unsigned CLK_HZ  = 27000000,
    parameter int unsigned BAUD    = 115200,
    parameter int unsigned COUNT_W = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [COUNT_W-1:0] count_in,
    output logic               uart_tx,
    output logic               busy
);

    localparam int unsigned     DIV      = CLK_HZ / BAUD;
    localparam int unsigned     CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef REPORT_DIR_EN
    localparam logic [1:0] LAST_BYTE = 2'd3;
`else
    localparam logic [1:0] LAST_BYTE = 2'd2;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // ASCII hex digit for a 4-bit value ('0'..'9', 'A'..'F').
    function automatic logic [7:0] hex_ascii(input logic [3:0] v);
        if (v < 4'd10) begin
            return 8'h30 + {4'h0, v};
        end else begin
            return 8'h41 + {4'h0, v - 4'd10};
        end
    endfunction

`ifdef REPORT_DIR_EN
    // Byte idx of the message: sign, digit, CR, LF.
    function automatic logic [7:0] msg_byte(input logic [1:0] idx,
                                            input logic [3:0] v,
                                            input logic       neg);
        case (idx)
            2'd0:    return neg ? 8'h2D : 8'h2B;
            2'd1:    return hex_ascii(v);
            2'd2:    return 8'h0D;
            2'd3:    return 8'h0A;
            default: return 8'h0A;
        endcase
    endfunction
`else
    // Byte idx of the message: digit, CR, LF.
    function automatic logic [7:0] msg_byte(input logic [1:0] idx,
                                            input logic [3:0] v);
        case (idx)
            2'd0:    return hex_ascii(v);
            2'd1:    return 8'h0D;
            2'd2:    return 8'h0A;
            default: return 8'h0A;
        endcase
    endfunction
`endif

    state_t             state_r,      state_s;
    logic [CNT_W-1:0]   baud_cnt_r,   baud_cnt_s;
    logic [2:0]         bit_cnt_r,    bit_cnt_s;
    logic [1:0]         byte_idx_r,   byte_idx_s;
    logic [7:0]         shift_r,      shift_s;
    logic [3:0]         snap_r,       snap_s;
    logic [COUNT_W-1:0] last_val_r,   last_val_s;
    logic               uart_tx_r,    uart_tx_s;
    logic               busy_r,       busy_s;
    logic               baud_done_s;
    logic [3:0]         count_ext_s;
`ifdef REPORT_DIR_EN
    logic               dir_neg_r,    dir_neg_s;
    logic [COUNT_W-1:0] delta_s;
`endif

    // Next-state and next-output logic for the transmit sequencer.
    always_comb begin
        state_s     = state_r;
        baud_cnt_s  = baud_cnt_r;
        bit_cnt_s   = bit_cnt_r;
        byte_idx_s  = byte_idx_r;
        shift_s     = shift_r;
        snap_s      = snap_r;
        last_val_s  = last_val_r;
        uart_tx_s   = uart_tx_r;
        busy_s      = busy_r;
        baud_done_s = (baud_cnt_r == DIV_LAST);
        count_ext_s = 4'(count_in);
`ifdef REPORT_DIR_EN
        dir_neg_s   = dir_neg_r;
        // Modular difference; its MSB is the sign of the shortest step.
        delta_s     = count_in - last_val_r;
`endif

        case (state_r)
            ST_IDLE: begin
                if (count_in != last_val_r) begin
                    // Start bit goes out on the very edge that sees the change.
                    snap_s     = count_ext_s;
                    last_val_s = count_in;
                    state_s    = ST_START;
                    uart_tx_s  = 1'b0;
                    busy_s     = 1'b1;
                    baud_cnt_s = '0;
                    bit_cnt_s  = 3'd0;
                    byte_idx_s = 2'd0;
`ifdef REPORT_DIR_EN
                    dir_neg_s  = delta_s[COUNT_W-1];
                    shift_s    = msg_byte(2'd0, count_ext_s, delta_s[COUNT_W-1]);
`else
                    shift_s    = msg_byte(2'd0, count_ext_s);
`endif
                end else begin
                    uart_tx_s  = 1'b1;
                    busy_s     = 1'b0;
                    baud_cnt_s = '0;
                end
            end

            ST_START: begin
                if (baud_done_s) begin
                    baud_cnt_s = '0;
                    bit_cnt_s  = 3'd0;
                    state_s    = ST_DATA;
                    uart_tx_s  = shift_r[0];
                end else begin
                    baud_cnt_s = baud_cnt_r + CNT_ONE;
                end
            end

            ST_DATA: begin
                if (baud_done_s) begin
                    baud_cnt_s = '0;
                    if (bit_cnt_r == 3'd7) begin
                        state_s   = ST_STOP;
                        uart_tx_s = 1'b1;
                    end else begin
                        // Bit currently on the line sits in shift_r[0]; next is [1].
                        bit_cnt_s = bit_cnt_r + 3'd1;
                        shift_s   = {1'b0, shift_r[7:1]};
                        uart_tx_s = shift_r[1];
                    end
                end else begin
                    baud_cnt_s = baud_cnt_r + CNT_ONE;
                end
            end

            ST_STOP: begin
                if (baud_done_s) begin
                    baud_cnt_s = '0;
                    if (byte_idx_r == LAST_BYTE) begin
                        state_s   = ST_IDLE;
                        busy_s    = 1'b0;
                        uart_tx_s = 1'b1;
                    end else begin
                        // Next byte follows with no idle gap.
                        byte_idx_s = byte_idx_r + 2'd1;
                        state_s    = ST_START;
                        uart_tx_s  = 1'b0;
`ifdef REPORT_DIR_EN
                        shift_s    = msg_byte(byte_idx_r + 2'd1, snap_r, dir_neg_r);
`else
                        shift_s    = msg_byte(byte_idx_r + 2'd1, snap_r);
`endif
                    end
                end else begin
                    baud_cnt_s = baud_cnt_r + CNT_ONE;
                end
            end

            default: begin
                state_s    = ST_IDLE;
                uart_tx_s  = 1'b1;
                busy_s     = 1'b0;
                baud_cnt_s = '0;
                byte_idx_s = 2'd0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r    <= ST_IDLE;
            baud_cnt_r <= '0;
            bit_cnt_r  <= 3'd0;
            byte_idx_r <= 2'd0;
            shift_r    <= 8'h00;
            snap_r     <= 4'h0;
            last_val_r <= '0;
            uart_tx_r  <= 1'b1;
            busy_r     <= 1'b0;
`ifdef REPORT_DIR_EN
            dir_neg_r  <= 1'b0;
`endif
        end else begin
            state_r    <= state_s;
            baud_cnt_r <= baud_cnt_s;
            bit_cnt_r  <= bit_cnt_s;
            byte_idx_r <= byte_idx_s;
            shift_r    <= shift_s;
            snap_r     <= snap_s;
            last_val_r <= last_val_s;
            uart_tx_r  <= uart_tx_s;
            busy_r     <= busy_s;
`ifdef REPORT_DIR_EN
            dir_neg_r  <= dir_neg_s;
`endif
        end
    end

    assign uart_tx = uart_tx_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_count_uart_reporter.sv
// -----------------------------------------------------------------------------
// Testbench for count_uart_reporter.
// A message-level reference model predicts, per clock edge, when a message
// starts, which bytes it carries and how long busy stays high. A UART
// decoder monitor reconstructs bytes from uart_tx and checks them, and their
// start times, against the expected-byte queue.
// -----------------------------------------------------------------------------
module tb_count_uart_reporter;

    localparam int CLK_HZ  = 1000000;
    localparam int BAUD    = 100000;
    localparam int COUNT_W = 4;
    localparam int DIV     = CLK_HZ / BAUD;
`ifdef REPORT_DIR_EN
    localparam int MSG_BYTES = 4;
`else
    localparam int MSG_BYTES = 3;
`endif

    logic               clk      = 1'b0;
    logic               rstn     = 1'b0;
    logic [COUNT_W-1:0] count_in = '0;
    logic               uart_tx;
    logic               busy;

    count_uart_reporter #(
        .CLK_HZ  (CLK_HZ),
        .BAUD    (BAUD),
        .COUNT_W (COUNT_W)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .count_in (count_in),
        .uart_tx  (uart_tx),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        int         start;   // edge number of the start bit, -1 if not first byte
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // model state
    int   m_last = 0;
    bit   m_busy = 1'b0;
    int   m_end  = 0;

    // decoder state
    int         d_state = 0;
    int         d_cnt   = 0;
    logic [7:0] d_byte  = 8'h00;

    function automatic logic [7:0] digit_ch(input int v);
        if (v < 10) return 8'(48 + v);
        else        return 8'(65 + v - 10);
    endfunction

    function automatic exp_t mk(input logic [7:0] b, input int start);
        exp_t e;
        e.b     = b;
        e.start = start;
        return e;
    endfunction

    // Reference model: one evaluation per rising edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (!rstn) begin
                exp_q.delete();
                m_last = 0;
                m_busy = 1'b0;
            end else if (!m_busy && int'(count_in) != m_last) begin
`ifdef REPORT_DIR_EN
                begin
                    int d;
                    d = (int'(count_in) - m_last + (1 << COUNT_W)) % (1 << COUNT_W);
                    exp_q.push_back(mk((d >= (1 << (COUNT_W - 1))) ? 8'h2D : 8'h2B, cyc));
                    exp_q.push_back(mk(digit_ch(int'(count_in)), -1));
                end
`else
                exp_q.push_back(mk(digit_ch(int'(count_in)), cyc));
`endif
                exp_q.push_back(mk(8'h0D, -1));
                exp_q.push_back(mk(8'h0A, -1));
                m_last = int'(count_in);
                m_busy = 1'b1;
                m_end  = cyc + 10 * MSG_BYTES * DIV;
            end else if (m_busy && cyc == m_end) begin
                m_busy = 1'b0;
            end
        end
    end

    // UART decoder / scoreboard checker, sampling on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                d_state = 0;
            end else if (d_state == 0) begin
                if (uart_tx === 1'b0) begin
                    d_state = 1;
                    d_cnt   = 0;
                    d_byte  = 8'h00;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL start_unexpected: start bit at edge %0d, required none", cyc);
                    end else if (exp_q[0].start >= 0) begin
                        total++;
                        if (exp_q[0].start != cyc) begin
                            bad++;
                            $display("FAIL start_time: start bit at edge %0d, required edge %0d",
                                     cyc, exp_q[0].start);
                        end
                    end
                end
            end else begin
                d_cnt++;
                if (d_cnt > DIV / 2 && (d_cnt - DIV / 2) % DIV == 0 && (d_cnt - DIV / 2) / DIV <= 8) begin
                    d_byte = {uart_tx, d_byte[7:1]};
                end
                if (d_cnt == DIV / 2 + 9 * DIV) begin
                    total++;
                    if (uart_tx !== 1'b1) begin
                        bad++;
                        $display("FAIL stop_bit: got %b at edge %0d, required 1", uart_tx, cyc);
                    end
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL byte_unexpected: got 8'h%02h at edge %0d, required none", d_byte, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        if (d_byte !== e.b) begin
                            bad++;
                            $display("FAIL byte_value: got 8'h%02h, required 8'h%02h (edge %0d)",
                                     d_byte, e.b, cyc);
                        end
                    end
                    d_state = 0;
                end
            end
        end
    end

    // busy and idle-line monitor: compares whenever busy, uart_tx or the model's busy change.
    initial begin
        logic prev_busy;
        logic prev_tx;
        bit   prev_exp;
        prev_busy = 1'bx;
        prev_tx   = 1'bx;
        prev_exp  = 1'b1;
        forever begin
            @(negedge clk);
            if (busy !== prev_busy || m_busy != prev_exp) begin
                total++;
                if (busy !== m_busy) begin
                    bad++;
                    $display("FAIL busy: got %b at edge %0d, required %b", busy, cyc, m_busy);
                end
            end
            if (!m_busy && (uart_tx !== prev_tx || m_busy != prev_exp)) begin
                total++;
                if (uart_tx !== 1'b1) begin
                    bad++;
                    $display("FAIL idle_tx: got %b at edge %0d, required 1", uart_tx, cyc);
                end
            end
            prev_busy = busy;
            prev_tx   = uart_tx;
            prev_exp  = m_busy;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Wait until every expected message has been transmitted, bounded.
    task automatic drain();
        int k;
        k = 0;
        wait_cycles(1);
        while ((m_busy || d_state != 0 || int'(count_in) != m_last) && k < 3000) begin
            wait_cycles(1);
            k++;
        end
        total++;
        if (k >= 3000) begin
            bad++;
            $display("FAIL drain_timeout: still busy after %0d cycles, required idle", k);
        end
        wait_cycles(2);
    endtask

    task automatic set_count(input int v);
        count_in = COUNT_W'(v);
    endtask

    // Stimulus.
    initial begin
        rstn     = 1'b0;
        count_in = '0;
        wait_cycles(3);
        rstn = 1'b1;

        // quiet line with count held at the reset value
        wait_cycles(1000);
        total++;
        if (uart_tx !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL quiet: got tx=%b busy=%b, required tx=1 busy=0", uart_tx, busy);
        end

        set_count(5);  drain();
        set_count(0);  drain();
        set_count(12); drain();
        set_count(0);  drain();

        // merged changes: 1, then 2 and 3 while busy -> "1", "3"
        set_count(1);
        wait_cycles(50);
        set_count(2);
        wait_cycles(70);
        set_count(3);
        drain();

        // reset in the middle of a frame
        set_count(0); drain();
        set_count(7);
        wait_cycles(45);
        rstn = 1'b0;
        wait_cycles(1);
        rstn = 1'b1;
        total++;
        if (uart_tx !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_abort: got tx=%b busy=%b, required tx=1 busy=0", uart_tx, busy);
        end
        drain();

        // wrap in both directions
        set_count(15); drain();
        set_count(0);  drain();
        set_count(15); drain();

        // random changes with occasional resets
        for (int i = 0; i < 40; i++) begin
            set_count(int'($urandom_range(0, 15)));
            if ($urandom_range(0, 9) == 0) begin
                wait_cycles(int'($urandom_range(1, 300)));
                rstn = 1'b0;
                wait_cycles(1);
                rstn = 1'b1;
            end else begin
                wait_cycles(int'($urandom_range(1, 350)));
            end
        end
        drain();

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover: %0d expected bytes never seen, required 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
